fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage of the 32-bit RISC core. It holds the program counter and issues word fetches to instruction memory over a req/ready handshake. Returned instructions pass to decode through a registered valid/ready output with a one-entry skid buffer. Its next-PC source is the 2:1 select between sequential PC+4 and the execute-stage redirect target. A redirect flushes everything younger and discards any response still in flight.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset; must be word aligned.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- redirect_valid  input  1  taken branch/jump from execute; highest priority.
- redirect_pc  input  32  redirect target.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch word address.
- imem_ready  input  1  memory accepts the request and returns imem_rdata in the same cycle.
- imem_rdata  input  32  instruction word; valid only when imem_req && imem_ready.
- if_valid  output  1  output slot holds an instruction.
- if_pc  output  32  PC of if_instr.
- if_instr  output  32  instruction to decode.
- if_ready  input  1  decode accepts the output slot this cycle.
- stat_fetch_cnt  output  32  delivered-instruction count (see Configuration).
- stat_drop_cnt  output  32  discarded-response count (see Configuration).

## Operation
- Registers:
  - pc: next address to fetch.
  - req_addr: address of the outstanding request.
  - Output slot: if_valid / if_pc / if_instr.
  - Skid slot: skid_valid / skid_pc / skid_instr.
  - state: ISSUE, WAIT or DROP.
- Sequential next PC = pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).
- ISSUE state:
  - imem_req = !skid_valid; imem_addr = pc.
  - req && ready: deliver the response; pc <= pc+4; stay in ISSUE.
  - req && !ready: req_addr <= pc; go to WAIT.
- WAIT state:
  - imem_req = 1; imem_addr = req_addr, held stable.
  - On ready: deliver; pc <= pc+4; go to ISSUE.
- DROP state:
  - imem_req = 1; imem_addr = req_addr.
  - On ready: discard the response; go to ISSUE.
- Delivery rules:
  - If the skid slot is empty and the output slot is free (!if_valid || if_ready), the response loads the output slot.
  - Otherwise the response loads the skid slot.
  - Whenever the output slot is consumed or empty and skid_valid = 1, the skid entry moves to the output slot in the same edge.
  - Program order is always preserved; at most 2 instructions are buffered.
- Redirect (redirect_valid = 1), overriding all of the above:
  - pc <= redirect_pc; if_valid <= 0; skid_valid <= 0.
  - This applies even if if_ready = 1 in the same cycle; decode has taken the old slot in that case.
  - Request outstanding without ready this cycle (ISSUE with req && !ready, WAIT, or DROP): go to or stay in DROP. req_addr keeps the old address; in ISSUE it captures the current pc.
  - Response arriving this same cycle: discard it; go to ISSUE.
  - No request this cycle: go to ISSUE.
  - A redirect while already in DROP only updates pc.
- Reset, in the cycle rst is high:
  - imem_req = 0; state <= ISSUE; pc <= RESET_PC.
  - if_valid, skid_valid <= 0; if_pc, if_instr <= 0; req_addr <= 0; both stat counters <= 0.
  - Reset mid-request abandons that request; memory must tolerate imem_req dropping.

## Timing
- First request is in the first cycle after rst deasserts, with imem_addr = RESET_PC.
- Request accepted at edge N: if_valid = 1 in cycle N+1.
- Zero-wait memory with if_ready held high sustains 1 instruction per cycle.
- With if_ready low and zero-wait memory:
  - The output slot fills, then the skid slot fills, then imem_req drops.
  - Fetch resumes in the cycle after skid_valid clears.
- Redirect at edge N:
  - if_valid = 0 in cycle N+1.
  - If no request is outstanding, a request to redirect_pc is issued in cycle N+1.
  - If a request is outstanding, the first target fetch is issued in the cycle after DROP completes.
- imem_req and imem_addr are combinational from state and skid_valid only. They must not depend on imem_ready.

## Configuration
- Macro FETCH_STAT_EN.
- Defined:
  - stat_fetch_cnt increments on every delivered (non-discarded) response.
  - stat_drop_cnt increments on every discarded response, whether in DROP or discarded by a same-cycle redirect.
  - Both counters are 32-bit and wrap.
- Undefined: both ports are tied to 32'h0 and no counter logic is built.

## Test plan
- Reset release, RESET_PC = 0, zero-wait memory returning addr^32'hA5A5_0000, if_ready = 1:
  - imem_addr sequence is 0, 4, 8, 12.
  - if_pc/if_instr pairs are (0, A5A5_0000), (4, A5A5_0004), ... starting the cycle after each accept.
- Zero-wait memory, if_ready = 0 for 5 cycles:
  - Exactly 2 requests (0, 4) are accepted, then imem_req = 0.
  - if_pc holds 0; releasing if_ready delivers 0, 4, 8 in order with no gap or duplicate.
- Memory with 3-cycle ready latency:
  - imem_addr is held at 0 for 3 cycles with imem_req = 1 (WAIT state).
  - Next address is 4.
- Redirect to 32'h100 in the 2nd wait cycle of a request to 8:
  - DROP holds imem_addr = 8 until ready; that response is discarded (stat_drop_cnt = 1).
  - Next request is 0x100; if_valid = 0 until 0x100 is delivered.
- Redirect to 32'h200 while both slots are full and if_ready = 1:
  - if_valid = 0 next cycle; the skid entry is never output.
  - Next delivered if_pc = 0x200.
- Redirect to 32'hFFFF_FFFC, zero-wait memory:
  - Delivered if_pc sequence is FFFF_FFFC, 0000_0000, 0000_0004.
  - Asserting rst mid-WAIT drops imem_req immediately; the first request after release is to RESET_PC.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: execute redirect, instruction-memory handshake, decode output slot
// and statistics. The master modport is the fetch stage, the slave modport its surroundings.
interface fetch_stage_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;
    logic [31:0] stat_fetch_cnt;
    logic [31:0] stat_drop_cnt;

    modport master (
        input  redirect_valid, redirect_pc, imem_ready, imem_rdata, if_ready,
        output imem_req, imem_addr, if_valid, if_pc, if_instr,
        output stat_fetch_cnt, stat_drop_cnt
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_ready, imem_rdata, if_ready,
        input  imem_req, imem_addr, if_valid, if_pc, if_instr,
        input  stat_fetch_cnt, stat_drop_cnt
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem req/ready fetch FSM, output slot plus one-entry skid buffer.
// Optional statistics counters are built when FETCH_STAT_EN is defined.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_stage_if.master        bus,
    output logic [1:0]           o_dbg_state
);

    // Handshakes: a transfer on imem happens in a cycle where imem_req && imem_ready;
    // the output slot transfers in a cycle where if_valid && if_ready. Neither side
    // may make its valid/req depend on the other side's ready in the same cycle.

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_req_addr;
    logic        r_if_valid;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_instr;
    logic        r_skid_valid;
    logic [31:0] r_skid_pc;
    logic [31:0] r_skid_instr;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_fire;
    logic        w_deliver;
    logic        w_out_free;
    logic        w_issue_stall;
    logic [31:0] w_pc_seq;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ISSUE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        if (bus.redirect_valid) begin
            // An unanswered request must still be drained; its data belongs to the old path.
            if (w_req && !bus.imem_ready) begin
                w_state_nxt = ST_DROP;
            end else begin
                w_state_nxt = ST_ISSUE;
            end
        end else begin
            case (r_state)
                ST_ISSUE: if (w_req && !bus.imem_ready) w_state_nxt = ST_WAIT;
                ST_WAIT:  if (bus.imem_ready)           w_state_nxt = ST_ISSUE;
                ST_DROP:  if (bus.imem_ready)           w_state_nxt = ST_ISSUE;
                default:                                w_state_nxt = ST_ISSUE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_req  = 1'b0;
        w_addr = r_req_addr;
        case (r_state)
            ST_ISSUE: begin
                w_req  = !r_skid_valid;
                w_addr = r_pc;
            end
            ST_WAIT, ST_DROP: begin
                w_req  = 1'b1;
                w_addr = r_req_addr;
            end
            default: begin
                w_req  = 1'b0;
                w_addr = r_pc;
            end
        endcase
        if (rst) begin
            w_req = 1'b0;
        end
    end

    assign w_fire        = w_req && bus.imem_ready;
    assign w_deliver     = w_fire && (r_state != ST_DROP) && !bus.redirect_valid;
    assign w_out_free    = !r_if_valid || bus.if_ready;
    assign w_issue_stall = (r_state == ST_ISSUE) && w_req && !bus.imem_ready;
    assign w_pc_seq      = r_pc + 32'd4;

    // ---------------- PC, request address, output and skid slots ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_req_addr   <= 32'h0;
            r_if_valid   <= 1'b0;
            r_if_pc      <= 32'h0;
            r_if_instr   <= 32'h0;
            r_skid_valid <= 1'b0;
            r_skid_pc    <= 32'h0;
            r_skid_instr <= 32'h0;
        end else begin
            if (bus.redirect_valid) begin
                r_pc <= bus.redirect_pc;
            end else if (w_deliver) begin
                r_pc <= w_pc_seq;
            end

            if (w_issue_stall) begin
                r_req_addr <= r_pc;
            end

            if (bus.redirect_valid) begin
                r_if_valid   <= 1'b0;
                r_skid_valid <= 1'b0;
            end else if (w_out_free) begin
                // Skid entry is older than any new response, so it goes out first.
                if (r_skid_valid) begin
                    r_if_valid <= 1'b1;
                    r_if_pc    <= r_skid_pc;
                    r_if_instr <= r_skid_instr;
                    if (w_deliver) begin
                        r_skid_pc    <= w_addr;
                        r_skid_instr <= bus.imem_rdata;
                    end else begin
                        r_skid_valid <= 1'b0;
                    end
                end else if (w_deliver) begin
                    r_if_valid <= 1'b1;
                    r_if_pc    <= w_addr;
                    r_if_instr <= bus.imem_rdata;
                end else begin
                    r_if_valid <= 1'b0;
                end
            end else if (w_deliver) begin
                r_skid_valid <= 1'b1;
                r_skid_pc    <= w_addr;
                r_skid_instr <= bus.imem_rdata;
            end
        end
    end

    assign bus.imem_req  = w_req;
    assign bus.imem_addr = w_addr;
    assign bus.if_valid  = r_if_valid;
    assign bus.if_pc     = r_if_pc;
    assign bus.if_instr  = r_if_instr;
    assign o_dbg_state   = r_state;

`ifdef FETCH_STAT_EN
    logic        w_discard;
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_drop_cnt;

    assign w_discard = w_fire && ((r_state == ST_DROP) || bus.redirect_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt <= 32'h0;
            r_drop_cnt  <= 32'h0;
        end else begin
            if (w_deliver) r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (w_discard) r_drop_cnt  <= r_drop_cnt + 32'd1;
        end
    end

    assign bus.stat_fetch_cnt = r_fetch_cnt;
    assign bus.stat_drop_cnt  = r_drop_cnt;
`else
    assign bus.stat_fetch_cnt = 32'h0;
    assign bus.stat_drop_cnt  = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: fixed vector table, directed corner sequences and random traffic
// checked against a queue-based model of fetch, buffering and redirect behaviour.
module tb_fetch_stage;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    fetch_stage_if bus();

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // Test memory: instruction word is the address with a fixed pattern folded in.
    assign bus.imem_rdata = bus.imem_addr ^ 32'hA5A5_0000;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: buffered instructions in program order (front = output slot).
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc_q[$];
    logic [31:0] m_pc        = 32'h0;
    logic        m_pend      = 1'b0;
    logic [31:0] m_pend_addr = 32'h0;
    logic        m_drop      = 1'b0;
    logic [31:0] m_fetch_cnt = 32'h0;
    logic [31:0] m_drop_cnt  = 32'h0;

    typedef struct {
        logic        rdy;
        logic        ifr;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs, let them settle, compare against the model.
    task automatic apply(input logic r, input logic rv, input logic [31:0] rp,
                         input logic rdy, input logic ifr);
        logic        e_req;
        logic [31:0] e_fetch;
        logic [31:0] e_drop;
        rst                = r;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rp;
        bus.imem_ready     = rdy;
        bus.if_ready       = ifr;
        #1;
        if (r) begin
            chk("req_in_reset", {31'b0, bus.imem_req}, 32'h0);
        end else begin
            e_req = m_pend || (exp_q.size() < 2);
            chk("imem_req", {31'b0, bus.imem_req}, {31'b0, e_req});
            if (e_req) chk("imem_addr", bus.imem_addr, m_pend ? m_pend_addr : m_pc);
            chk("if_valid", {31'b0, bus.if_valid}, {31'b0, exp_q.size() > 0});
            if (exp_q.size() > 0) begin
                chk("if_pc", bus.if_pc, exp_pc_q[0]);
                chk("if_instr", bus.if_instr, exp_q[0]);
            end
`ifdef FETCH_STAT_EN
            e_fetch = m_fetch_cnt;
            e_drop  = m_drop_cnt;
`else
            e_fetch = 32'h0;
            e_drop  = 32'h0;
`endif
            chk("stat_fetch_cnt", bus.stat_fetch_cnt, e_fetch);
            chk("stat_drop_cnt", bus.stat_drop_cnt, e_drop);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven, then clock the DUT.
    task automatic advance();
        logic        e_req;
        logic        fire;
        logic [31:0] addr;
        if (rst) begin
            exp_q.delete();
            exp_pc_q.delete();
            m_pc        = 32'h0;
            m_pend      = 1'b0;
            m_drop      = 1'b0;
            m_fetch_cnt = 32'h0;
            m_drop_cnt  = 32'h0;
        end else begin
            e_req = m_pend || (exp_q.size() < 2);
            addr  = m_pend ? m_pend_addr : m_pc;
            fire  = e_req && bus.imem_ready;
            if (exp_q.size() > 0 && bus.if_ready) begin
                void'(exp_q.pop_front());
                void'(exp_pc_q.pop_front());
            end
            if (bus.redirect_valid) begin
                exp_q.delete();
                exp_pc_q.delete();
                if (fire) begin
                    m_drop_cnt = m_drop_cnt + 1;
                    m_pend     = 1'b0;
                    m_drop     = 1'b0;
                end else if (e_req) begin
                    if (!m_pend) m_pend_addr = m_pc;
                    m_pend = 1'b1;
                    m_drop = 1'b1;
                end
                m_pc = bus.redirect_pc;
            end else if (fire) begin
                if (m_drop) begin
                    m_drop_cnt = m_drop_cnt + 1;
                end else begin
                    exp_q.push_back(addr ^ 32'hA5A5_0000);
                    exp_pc_q.push_back(addr);
                    m_fetch_cnt = m_fetch_cnt + 1;
                    m_pc        = m_pc + 32'd4;
                end
                m_pend = 1'b0;
                m_drop = 1'b0;
            end else if (e_req && !m_pend) begin
                m_pend      = 1'b1;
                m_pend_addr = m_pc;
                m_drop      = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rp;
        logic [31:0] exp_drop1;

        // Reset release, zero-wait memory, then output stall and a single wait state.
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 32'h0000_000C, 1'b1, 32'h0000_0008};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0010, 1'b1, 32'h0000_0008};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0010, 1'b1, 32'h0000_0008};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0010, 1'b1, 32'h0000_0008};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_000C};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0014, 1'b1, 32'h0000_0010};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0014, 1'b0, 32'h0};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 32'h0000_0014, 1'b0, 32'h0};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 32'h0000_0018, 1'b1, 32'h0000_0014};

`ifdef FETCH_STAT_EN
        exp_drop1 = 32'd1;
`else
        exp_drop1 = 32'd0;
`endif

        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.imem_ready     = 1'b0;
        bus.if_ready       = 1'b0;
        @(negedge clk);
        apply(1'b1, 1'b0, 32'h0, 1'b1, 1'b1); advance();
        apply(1'b1, 1'b0, 32'h0, 1'b1, 1'b1); advance();

        for (int i = 0; i < 12; i++) begin
            apply(1'b0, 1'b0, 32'h0, tbl[i].rdy, tbl[i].ifr);
            chk("tbl_req", {31'b0, bus.imem_req}, {31'b0, tbl[i].exp_req});
            if (tbl[i].exp_req) chk("tbl_addr", bus.imem_addr, tbl[i].exp_addr);
            chk("tbl_valid", {31'b0, bus.if_valid}, {31'b0, tbl[i].exp_valid});
            if (tbl[i].exp_valid) begin
                chk("tbl_pc", bus.if_pc, tbl[i].exp_pc);
                chk("tbl_instr", bus.if_instr, tbl[i].exp_pc ^ 32'hA5A5_0000);
            end
            advance();
        end

        // Three-cycle memory latency: address held at RESET_PC, then PC+4.
        apply(1'b1, 1'b0, 32'h0, 1'b1, 1'b1); advance();
        apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("lat_addr0", bus.imem_addr, 32'h0); advance();
        apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("lat_addr1", bus.imem_addr, 32'h0);
        chk("lat_dbg_wait", {30'b0, dbg_state}, 32'd1); advance();
        apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("lat_addr2", bus.imem_addr, 32'h0); advance();
        apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("lat_next", bus.imem_addr, 32'h4); advance();

        // Redirect to 0x100 while the request to 8 is waiting: drained, discarded.
        apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("drop_wait_addr", bus.imem_addr, 32'h8); advance();
        apply(1'b0, 1'b1, 32'h100, 1'b0, 1'b1); advance();
        apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("drop_hold_addr", bus.imem_addr, 32'h8);
        chk("drop_hold_valid", {31'b0, bus.if_valid}, 32'h0); advance();
        apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("drop_last_addr", bus.imem_addr, 32'h8); advance();
        apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("redir_addr", bus.imem_addr, 32'h100);
        chk("redir_valid0", {31'b0, bus.if_valid}, 32'h0);
        chk("redir_drop_cnt", bus.stat_drop_cnt, exp_drop1); advance();
        apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("redir_pc", bus.if_pc, 32'h100); advance();

        // Both slots full, redirect with if_ready=1: skid entry never appears.
        apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b0); advance();
        apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("full_req", {31'b0, bus.imem_req}, 32'h0); advance();
        apply(1'b0, 1'b1, 32'h200, 1'b1, 1'b1); advance();
        apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("full_valid0", {31'b0, bus.if_valid}, 32'h0);
        chk("full_addr", bus.imem_addr, 32'h200); advance();
        apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("full_pc", bus.if_pc, 32'h200); advance();

        // PC wrap.
        apply(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1); advance();
        apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC); advance();
        apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("wrap_pc0", bus.if_pc, 32'hFFFF_FFFC); advance();
        apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("wrap_pc1", bus.if_pc, 32'h0); advance();
        apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("wrap_pc2", bus.if_pc, 32'h4); advance();

        // Reset in the middle of a wait.
        apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b1); advance();
        apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("rst_mid_wait_req", {31'b0, bus.imem_req}, 32'h0); advance();
        apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("rst_first_addr", bus.imem_addr, 32'h0);
        chk("rst_first_req", {31'b0, bus.imem_req}, 32'h1); advance();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 0) rp = $urandom() & 32'hFFFF_FFFC;
            else rp = 32'hFFFF_FFF0 | ($urandom_range(0, 3) << 2);
            apply($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0, rp,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
